// File: rtl/pc_flow_ctrl_if.sv
// Request/response bundle between the main control FSM and pc_flow_ctrl.
// master = main control side, slave = pc_flow_ctrl.
`timescale 1ns/1ps
interface pc_flow_ctrl_if;
  logic       fetch_req;
  logic       branch_req;
  logic       branch_ne;
  logic       alu_zero;
  logic       jump_req;
  logic       rte_req;
  logic       exc_opcode;
  logic       exc_ovf;
  logic       exc_div0;
  logic [2:0] pc_src_sel;
  logic       pc_write;
  logic       epc_write;
  logic       alu_pc_minus4;
  logic       exc_mem_rd;
  logic [7:0] exc_addr;
  logic [1:0] exc_cause;
  logic       busy;

  modport master (
    output fetch_req, branch_req, branch_ne, alu_zero, jump_req, rte_req,
           exc_opcode, exc_ovf, exc_div0,
    input  pc_src_sel, pc_write, epc_write, alu_pc_minus4, exc_mem_rd,
           exc_addr, exc_cause, busy
  );

  modport slave (
    input  fetch_req, branch_req, branch_ne, alu_zero, jump_req, rte_req,
           exc_opcode, exc_ovf, exc_div0,
    output pc_src_sel, pc_write, epc_write, alu_pc_minus4, exc_mem_rd,
           exc_addr, exc_cause, busy
  );
endinterface

// File: rtl/pc_flow_ctrl.sv
// Next-PC sequencer: one-cycle PC updates plus the multi-cycle exception entry.
// Optional feature macro: PCCTRL_DIV0_EXC_EN enables the divide-by-zero exception.
`timescale 1ns/1ps
module pc_flow_ctrl #(
  parameter int         MEM_LAT    = 2,
  parameter logic [7:0] VEC_OPCODE = 8'd253,
  parameter logic [7:0] VEC_OVF    = 8'd254,
  parameter logic [7:0] VEC_DIV0   = 8'd255
) (
  input  logic          clk,
  input  logic          reset,
  pc_flow_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {IDLE, EXC_EPC, EXC_WAIT, EXC_LOAD} state_t;

  state_t           state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic [2:0]       sel, selNext;
  logic [7:0]       addr, addrNext;
  logic [1:0]       cause, causeNext;
  logic             pcWr, pcWrNext;
  logic             epcWr, epcWrNext;
  logic             minus4, minus4Next;
  logic             memRd, memRdNext;
  logic             busyQ, busyNext;
  logic             div0Hit;
  logic             brTaken;

`ifdef PCCTRL_DIV0_EXC_EN
  assign div0Hit = bus.exc_div0;
`else
  assign div0Hit = 1'b0 & bus.exc_div0;
`endif

  assign brTaken = bus.alu_zero ^ bus.branch_ne;

  // Outputs are computed for the coming cycle and registered with the state.
  always_comb begin
    stateNext  = state;
    cntNext    = cnt;
    selNext    = sel;
    addrNext   = addr;
    causeNext  = cause;
    pcWrNext   = 1'b0;
    epcWrNext  = 1'b0;
    minus4Next = 1'b0;
    memRdNext  = 1'b0;
    busyNext   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.exc_opcode || bus.exc_ovf || div0Hit) begin
          stateNext  = EXC_EPC;
          epcWrNext  = 1'b1;
          minus4Next = 1'b1;
          memRdNext  = 1'b1;
          busyNext   = 1'b1;
          if (bus.exc_opcode) begin
            causeNext = 2'b01;
            addrNext  = VEC_OPCODE;
          end else if (bus.exc_ovf) begin
            causeNext = 2'b10;
            addrNext  = VEC_OVF;
          end else begin
            causeNext = 2'b11;
            addrNext  = VEC_DIV0;
          end
        end else if (bus.rte_req) begin
          selNext  = 3'b100;
          pcWrNext = 1'b1;
        end else if (bus.jump_req) begin
          selNext  = 3'b010;
          pcWrNext = 1'b1;
        end else if (bus.branch_req) begin
          if (brTaken) begin
            selNext  = 3'b001;
            pcWrNext = 1'b1;
          end
        end else if (bus.fetch_req) begin
          selNext  = 3'b000;
          pcWrNext = 1'b1;
        end
      end
      EXC_EPC: begin
        stateNext = EXC_WAIT;
        cntNext   = CNT_W'(MEM_LAT);
        memRdNext = 1'b1;
        busyNext  = 1'b1;
      end
      EXC_WAIT: begin
        busyNext = 1'b1;
        if (cnt == CNT_W'(1)) begin
          stateNext = EXC_LOAD;
          selNext   = 3'b011;
          pcWrNext  = 1'b1;
        end else begin
          cntNext   = cnt - CNT_W'(1);
          memRdNext = 1'b1;
        end
      end
      EXC_LOAD: begin
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      sel    <= 3'b000;
      addr   <= 8'd0;
      cause  <= 2'b00;
      pcWr   <= 1'b0;
      epcWr  <= 1'b0;
      minus4 <= 1'b0;
      memRd  <= 1'b0;
      busyQ  <= 1'b0;
    end else begin
      state  <= stateNext;
      cnt    <= cntNext;
      sel    <= selNext;
      addr   <= addrNext;
      cause  <= causeNext;
      pcWr   <= pcWrNext;
      epcWr  <= epcWrNext;
      minus4 <= minus4Next;
      memRd  <= memRdNext;
      busyQ  <= busyNext;
    end
  end

  assign bus.pc_src_sel    = sel;
  assign bus.pc_write      = pcWr;
  assign bus.epc_write     = epcWr;
  assign bus.alu_pc_minus4 = minus4;
  assign bus.exc_mem_rd    = memRd;
  assign bus.exc_addr      = addr;
  assign bus.exc_cause     = cause;
  assign bus.busy          = busyQ;

endmodule

// File: tb/tb_pc_flow_ctrl.sv
// Self-checking bench for pc_flow_ctrl: cycle model with a schedule queue plus
// directed vectors with literal expectations.
`timescale 1ns/1ps
module tb_pc_flow_ctrl;

  localparam int MEM_LAT = 2;

  typedef struct packed {
    logic [2:0] sel;
    logic       pw;
    logic       ew;
    logic       m4;
    logic       rd;
    logic [7:0] addr;
    logic [1:0] cause;
    logic       busy;
  } outs_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   nTests = 0;
  int   nFail = 0;
  logic cmpEn = 1'b0;

  pc_flow_ctrl_if bus();

  pc_flow_ctrl #(.MEM_LAT(MEM_LAT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Model: each cycle's expected outputs; exception entry is pre-scheduled.
  outs_t cur = '0;
  outs_t nx;
  outs_t tmp;
  outs_t pend[$];
  logic  modelExc;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur = '0;
      pend.delete();
    end else begin
      nx = cur;
      nx.pw = 1'b0; nx.ew = 1'b0; nx.m4 = 1'b0; nx.rd = 1'b0; nx.busy = 1'b0;
`ifdef PCCTRL_DIV0_EXC_EN
      modelExc = bus.exc_opcode | bus.exc_ovf | bus.exc_div0;
`else
      modelExc = bus.exc_opcode | bus.exc_ovf;
`endif
      if (cur.busy) begin
        if (pend.size() > 0) nx = pend.pop_front();
      end else if (modelExc) begin
        if (bus.exc_opcode)   begin nx.cause = 2'd1; nx.addr = 8'd253; end
        else if (bus.exc_ovf) begin nx.cause = 2'd2; nx.addr = 8'd254; end
        else                  begin nx.cause = 2'd3; nx.addr = 8'd255; end
        nx.ew = 1'b1; nx.m4 = 1'b1; nx.rd = 1'b1; nx.busy = 1'b1;
        tmp = nx; tmp.ew = 1'b0; tmp.m4 = 1'b0;
        for (int i = 0; i < MEM_LAT; i++) pend.push_back(tmp);
        tmp.rd = 1'b0; tmp.sel = 3'd3; tmp.pw = 1'b1;
        pend.push_back(tmp);
      end else if (bus.rte_req) begin
        nx.sel = 3'd4; nx.pw = 1'b1;
      end else if (bus.jump_req) begin
        nx.sel = 3'd2; nx.pw = 1'b1;
      end else if (bus.branch_req) begin
        if (bus.alu_zero != bus.branch_ne) begin nx.sel = 3'd1; nx.pw = 1'b1; end
      end else if (bus.fetch_req) begin
        nx.sel = 3'd0; nx.pw = 1'b1;
      end
      cur = nx;
    end
  end

  outs_t dutV;
  always_comb dutV = {bus.pc_src_sel, bus.pc_write, bus.epc_write, bus.alu_pc_minus4,
                      bus.exc_mem_rd, bus.exc_addr, bus.exc_cause, bus.busy};

  always @(negedge clk) begin
    if (cmpEn) begin
      nTests++;
      if (dutV !== cur) begin
        nFail++;
        $display("FAIL model_cycle t=%0t: got sel=%0d pw=%b ew=%b m4=%b rd=%b addr=%0d cause=%0d busy=%b, required sel=%0d pw=%b ew=%b m4=%b rd=%b addr=%0d cause=%0d busy=%b",
                 $time, dutV.sel, dutV.pw, dutV.ew, dutV.m4, dutV.rd, dutV.addr, dutV.cause, dutV.busy,
                 cur.sel, cur.pw, cur.ew, cur.m4, cur.rd, cur.addr, cur.cause, cur.busy);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic setIn(input logic f, br, ne, z, j, r, eo, ev, ed);
    bus.fetch_req  = f;
    bus.branch_req = br;
    bus.branch_ne  = ne;
    bus.alu_zero   = z;
    bus.jump_req   = j;
    bus.rte_req    = r;
    bus.exc_opcode = eo;
    bus.exc_ovf    = ev;
    bus.exc_div0   = ed;
  endtask

  task automatic clrIn();
    setIn(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic pwSeen;

  initial begin
    clrIn();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", 32'(dutV), 32'd0);
    reset = 1'b1;
    cmpEn = 1'b1;

    // single fetch
    setIn(1, 0, 0, 0, 0, 0, 0, 0, 0); step(); clrIn();
    chk("fetch_pw", 32'(bus.pc_write), 32'd1);
    chk("fetch_sel", 32'(bus.pc_src_sel), 32'd0);
    step();
    chk("fetch_pw_drop", 32'(bus.pc_write), 32'd0);

    // three back-to-back fetches
    setIn(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(); chk("b2b_pw1", 32'(bus.pc_write), 32'd1);
    step(); chk("b2b_pw2", 32'(bus.pc_write), 32'd1);
    step(); chk("b2b_pw3", 32'(bus.pc_write), 32'd1);
    clrIn(); step(); chk("b2b_pw_end", 32'(bus.pc_write), 32'd0);

    // branches
    setIn(0, 1, 0, 1, 0, 0, 0, 0, 0); step(); clrIn();
    chk("beq_taken", {29'd0, bus.pc_src_sel}, 32'd1);
    chk("beq_taken_pw", 32'(bus.pc_write), 32'd1);
    setIn(0, 0, 0, 0, 1, 0, 0, 0, 0); step(); clrIn();
    chk("jump_sel", {29'd0, bus.pc_src_sel}, 32'd2);
    setIn(0, 1, 0, 0, 0, 0, 0, 0, 0); step(); clrIn();
    chk("beq_not_taken_pw", 32'(bus.pc_write), 32'd0);
    chk("beq_not_taken_sel_held", {29'd0, bus.pc_src_sel}, 32'd2);
    setIn(0, 1, 1, 0, 0, 0, 0, 0, 0); step(); clrIn();
    chk("bne_taken", {28'd0, bus.pc_src_sel, bus.pc_write}, {28'd0, 3'd1, 1'b1});
    setIn(0, 1, 1, 1, 0, 0, 0, 0, 0); step(); clrIn();
    chk("bne_not_taken_pw", 32'(bus.pc_write), 32'd0);

    // overflow exception entry
    setIn(0, 0, 0, 0, 0, 0, 0, 1, 0); step(); clrIn();
    chk("ovf_n1_epc", {bus.epc_write, bus.alu_pc_minus4, bus.exc_mem_rd, bus.busy, bus.pc_write}, 32'b11110);
    chk("ovf_n1_addr", 32'(bus.exc_addr), 32'd254);
    chk("ovf_n1_cause", 32'(bus.exc_cause), 32'd2);
    step();
    chk("ovf_n2", {bus.exc_mem_rd, bus.busy, bus.epc_write, bus.pc_write}, 32'b1100);
    step();
    chk("ovf_n3", {bus.exc_mem_rd, bus.busy, bus.epc_write, bus.pc_write}, 32'b1100);
    step();
    chk("ovf_n4_load", {bus.pc_src_sel, bus.pc_write, bus.busy, bus.exc_mem_rd}, {3'd3, 1'b1, 1'b1, 1'b0});
    step();
    chk("ovf_n5_idle", {bus.busy, bus.pc_write}, 32'd0);
    chk("ovf_cause_held", 32'(bus.exc_cause), 32'd2);

    // simultaneous opcode+ovf+jump, then jump while busy
    setIn(0, 0, 0, 0, 1, 0, 1, 1, 0); step(); clrIn();
    chk("prio_cause", 32'(bus.exc_cause), 32'd1);
    chk("prio_addr", 32'(bus.exc_addr), 32'd253);
    chk("prio_no_jump", {bus.pc_write, bus.epc_write}, 32'b01);
    setIn(0, 0, 0, 0, 1, 0, 0, 0, 0); step(); clrIn();
    chk("busy_jump_ignored", {bus.pc_src_sel, bus.pc_write}, {3'd3, 1'b0});
    step(); step();
    chk("prio_load", {bus.pc_src_sel, bus.pc_write}, {3'd3, 1'b1});
    step();

    // reset during EXC_WAIT
    setIn(0, 0, 0, 0, 0, 0, 0, 1, 0); step(); clrIn();
    @(posedge clk);
    #2 reset = 1'b0;
    #1 chk("async_reset_outs", 32'(dutV), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    pwSeen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      pwSeen = pwSeen | bus.pc_write | bus.epc_write;
    end
    chk("no_write_after_reset", 32'(pwSeen), 32'd0);
    setIn(0, 0, 0, 0, 0, 1, 0, 0, 0); step(); clrIn();
    chk("rte", {bus.pc_src_sel, bus.pc_write}, {3'd4, 1'b1});

    // div0 alone
    setIn(0, 0, 0, 0, 0, 0, 0, 0, 1); step(); clrIn();
`ifdef PCCTRL_DIV0_EXC_EN
    chk("div0_cause", 32'(bus.exc_cause), 32'd3);
    chk("div0_addr", 32'(bus.exc_addr), 32'd255);
    chk("div0_busy", 32'(bus.busy), 32'd1);
`else
    chk("div0_ignored_busy", 32'(bus.busy), 32'd0);
    chk("div0_ignored_pw", {bus.pc_write, bus.epc_write}, 32'd0);
    chk("div0_ignored_cause", 32'(bus.exc_cause), 32'd0);
`endif
    repeat (5) step();

    cmpEn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/pc_flow_ctrl.md
# pc_flow_ctrl

Sequencer for the next-PC path of the multicycle CPU. Accepts one-cycle PC-update requests from the main control unit and issues the matching `PcSource` select plus `PCWrite` strobe. Runs the multi-cycle exception entry: EPC capture, exception-vector byte read from memory, load of the sign-extended vector into PC. Sits between the main control FSM and the `PcSource` mux, PC register and EPC register.

## Interface
Parameters:
- `MEM_LAT`, 2: memory read latency in cycles for the vector fetch; legal range ≥1.
- `VEC_OPCODE`, 8'd253: vector byte address, invalid opcode.
- `VEC_OVF`, 8'd254: vector byte address, arithmetic overflow.
- `VEC_DIV0`, 8'd255: vector byte address, divide by zero.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: reset; one clock; reset is asynchronous and active-low.
- `fetch_req` in 1: sequential PC+4 update (also used for `jr`, rs through ALU).
- `branch_req` in 1: conditional branch.
- `branch_ne` in 1: 1 = `bne`, 0 = `beq`; sampled with `branch_req`.
- `alu_zero` in 1: ALU zero flag; sampled with `branch_req`.
- `jump_req` in 1: `j`/`jal` target.
- `rte_req` in 1: return from exception.
- `exc_opcode` in 1: invalid-opcode exception.
- `exc_ovf` in 1: overflow exception.
- `exc_div0` in 1: divide-by-zero exception.
- `pc_src_sel` out 3: `PcSource` select (000 AluOutDirect, 001 AluOut, 010 instr<<2, 011 MemSignExtend, 100 EPC).
- `pc_write` out 1: PC register write strobe.
- `epc_write` out 1: EPC register write strobe.
- `alu_pc_minus4` out 1: asks main control to drive ALU with PC-4 this cycle.
- `exc_mem_rd` out 1: memory read request for the vector byte.
- `exc_addr` out 8: vector byte address; valid while `exc_mem_rd`=1.
- `exc_cause` out 2: 00 none, 01 opcode, 10 overflow, 11 div0.
- `busy` out 1: exception entry in progress; control must not issue requests.

## Operation
- States: IDLE, EXC_EPC, EXC_WAIT, EXC_LOAD.
- IDLE priority: exception > `rte_req` > `jump_req` > `branch_req` > `fetch_req`. Among exceptions: opcode > ovf > div0.
- IDLE, request sampled at edge N:
  - Outputs are registered and valid during cycle N+1.
  - fetch: sel 000, `pc_write`=1.
  - jump: sel 010, `pc_write`=1.
  - rte: sel 100, `pc_write`=1.
  - branch: taken iff `alu_zero ^ branch_ne`. Taken gives sel 001, `pc_write`=1. Not taken gives `pc_write`=0 and sel unchanged.
- Exception sampled at edge N:
  - Go to EXC_EPC and latch `exc_cause` and `exc_addr`.
  - EXC_EPC (1 cycle): `epc_write`=1, `alu_pc_minus4`=1, `exc_mem_rd`=1, `busy`=1.
  - EXC_WAIT (`MEM_LAT` cycles, down-counter): `exc_mem_rd`=1, `busy`=1.
  - EXC_LOAD (1 cycle): sel 011, `pc_write`=1, `busy`=1, `exc_mem_rd`=0. Then IDLE.
- `exc_cause` holds its value until the next exception is accepted.
- `pc_src_sel` holds its last value when `pc_write`=0.
- All request and exception inputs are ignored while `busy`=1; nothing is queued.
- Counter width is `$clog2(MEM_LAT+1)`. It loads `MEM_LAT` on entry to EXC_WAIT and exits when it reaches 1.

## Timing
- Reset values: all outputs 0, `pc_src_sel`=000, state IDLE, counter 0.
- Reset asserted mid-exception: immediate return to IDLE. No `pc_write` or `epc_write` is issued afterwards.
- Simple requests: latency 1 cycle. Back-to-back requests every cycle are accepted.
- Exception entry: `epc_write` at N+1, `pc_write` at N+2+`MEM_LAT` (N+4 at default). `busy` is high for `MEM_LAT`+2 cycles.
- Simultaneous exception and any other request: the exception wins and the other request is dropped.

## Configuration
- `PCCTRL_DIV0_EXC_EN`:
  - Defined: `exc_div0` is recognised at lowest exception priority and produces cause 11, vector `VEC_DIV0`.
  - Undefined: the port is present but ignored, and cause 11 is never produced.

## Test plan
- After reset: all outputs 0. `fetch_req` pulse gives `pc_write`=1, sel 000 the next cycle. Three consecutive `fetch_req` give three consecutive `pc_write` pulses.
- `branch_req`=1, `branch_ne`=0, `alu_zero`=1 gives sel 001 with `pc_write`=1. Same with `alu_zero`=0 gives no write and sel unchanged. `bne` with `alu_zero`=0 is taken.
- `exc_ovf` pulse, `MEM_LAT`=2:
  - N+1: `epc_write`=1, `exc_addr`=254, `exc_cause`=10.
  - N+2..N+3: `exc_mem_rd`=1.
  - N+4: sel 011 with `pc_write`=1.
  - `busy` high N+1..N+4.
- `exc_opcode`, `exc_ovf` and `jump_req` together: cause 01, `exc_addr`=253, no jump issued. `jump_req` during `busy` is ignored.
- `reset` low during EXC_WAIT: outputs 0 immediately, no later `pc_write`. Then `rte_req` gives sel 100 with `pc_write`=1.
- `exc_div0` alone: with `PCCTRL_DIV0_EXC_EN`, cause 11, vector 255. Without it, no response and `busy` stays 0.
